// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network weight path.
//
// Holds the default geometry of one weight load (word width, words per row,
// rows per load, row address width), the row typedef, the loader FSM state
// enum and a small width helper used to size counters.
package nn_pkg;

    localparam int unsigned WORD_W_DEF = 10;  // bits per weight word
    localparam int unsigned WORDS_DEF  = 10;  // words per row (one neuron)
    localparam int unsigned ROWS_DEF   = 10;  // rows per load (neurons per layer)
    localparam int unsigned ADDR_W_DEF = 5;   // row address width

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef word_t row_t [WORDS_DEF];

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StWrite,
        StFinish
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// Serial-to-parallel assembler for a single weight word.
//
// Bits arrive MSB first and are shifted into the LSB. word_next is the value
// the word takes once the current bit is accepted, so the parent can capture
// a completed word in the same cycle its last bit is accepted.
//
// Optional feature macro: WEIGHT_LOADER_PARITY_EN. When defined, each word is
// followed by one even-parity bit; par_bit marks that bit (it is not shifted
// into the word) and par_err flags a mismatch combinationally.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   clr       restart word and parity accumulation (start of a load)
//   shift_en  accept in_bit this cycle
//   par_bit   (parity build) current bit is the parity bit
//   par_err   (parity build) accepted parity bit does not match the word
//   in_bit    serial data bit
//   word_next word value including the current bit
module serial_word_shifter
    import nn_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
`ifdef WEIGHT_LOADER_PARITY_EN
    input  logic              par_bit,
    output logic              par_err,
`endif
    input  logic              in_bit,
    output logic [WORD_W-1:0] word_next
);

    logic [WORD_W-1:0] word_q, word_d;

`ifdef WEIGHT_LOADER_PARITY_EN
    // Running XOR of the data bits of the word being assembled.
    logic par_q, par_d;
`endif

    always_comb begin
        word_next = {word_q[WORD_W-2:0], in_bit};
        word_d    = word_q;
`ifdef WEIGHT_LOADER_PARITY_EN
        par_d   = par_q;
        par_err = 1'b0;
        if (clr) begin
            word_d = '0;
            par_d  = 1'b0;
        end else if (shift_en) begin
            if (par_bit) begin
                // Even parity: data bits XOR parity bit must be zero.
                par_err = par_q ^ in_bit;
                par_d   = 1'b0;
            end else begin
                word_d = word_next;
                par_d  = par_q ^ in_bit;
            end
        end
`else
        if (clr) begin
            word_d = '0;
        end else if (shift_en) begin
            word_d = word_next;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
`ifdef WEIGHT_LOADER_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            word_q <= word_d;
`ifdef WEIGHT_LOADER_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Serial weight loader: receives a bit stream (MSB first, word 0 first),
// assembles ROWS rows of WORDS words and writes each completed row into the
// weight RAM with a one-cycle strobe, then pulses done.
//
// Optional feature macro: WEIGHT_LOADER_PARITY_EN. When defined, every word
// carries a trailing even-parity bit; a mismatch sets the sticky err flag,
// drops the row being assembled and returns to idle without done. When not
// defined, err is tied low and no parity bit is expected.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     one-cycle request to begin a load (ignored unless idle)
//   in_valid  serial bit qualifier
//   in_bit    serial weight data
//   in_ready  loader is accepting serial bits
//   wr_en     one-cycle row write strobe
//   wr_addr   row address for wr_en
//   wr_data   assembled row, word 0 in entry 0
//   busy      loader is not idle
//   done      one-cycle pulse after the last row write
//   err       sticky parity error flag
module weight_loader
    import nn_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned WORDS  = WORDS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data [WORDS],
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef WEIGHT_LOADER_PARITY_EN
    localparam int unsigned BITS_PER_WORD = WORD_W + 1;
`else
    localparam int unsigned BITS_PER_WORD = WORD_W;
`endif
    localparam int unsigned BIT_CNT_W  = clog2_min1(BITS_PER_WORD);
    localparam int unsigned WORD_CNT_W = clog2_min1(WORDS);

    localparam logic [BIT_CNT_W-1:0]  LAST_BIT      = BIT_CNT_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_DATA_BIT = BIT_CNT_W'(WORD_W - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD     = WORD_CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0]     LAST_ROW      = ADDR_W'(ROWS - 1);

    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]     row_cnt_q, row_cnt_d;
    logic [WORD_W-1:0]     row_q [WORDS];
    logic [WORD_W-1:0]     row_d [WORDS];

    logic              shift_en;
    logic              clr;
    logic              word_ok;
    logic [WORD_W-1:0] word_next;

`ifdef WEIGHT_LOADER_PARITY_EN
    logic err_q, err_d;
    logic par_bit;
    logic par_err;

    assign par_bit = (bit_cnt_q == LAST_BIT);
    assign word_ok = ~par_err;
    assign err     = err_q;
`else
    assign word_ok = 1'b1;
    assign err     = 1'b0;
`endif

    serial_word_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .shift_en  (shift_en),
`ifdef WEIGHT_LOADER_PARITY_EN
        .par_bit   (par_bit),
        .par_err   (par_err),
`endif
        .in_bit    (in_bit),
        .word_next (word_next)
    );

    assign wr_addr = row_cnt_q;
    assign wr_data = row_q;
    assign busy    = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        row_d      = row_q;
        shift_en   = 1'b0;
        clr        = 1'b0;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
`ifdef WEIGHT_LOADER_PARITY_EN
        err_d      = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StShift;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    row_cnt_d  = '0;
                    clr        = 1'b1;
`ifdef WEIGHT_LOADER_PARITY_EN
                    err_d      = 1'b0;
`endif
                end
            end

            StShift: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Capture the word as soon as its last data bit lands;
                    // wr_data therefore only changes once the next row starts.
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        row_d[word_cnt_q] = word_next;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (!word_ok) begin
                            state_d = StIdle;
`ifdef WEIGHT_LOADER_PARITY_EN
                            err_d   = 1'b1;
`endif
                        end else if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = StWrite;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end
                end
            end

            StWrite: begin
                wr_en = 1'b1;
                if (row_cnt_q == LAST_ROW) begin
                    state_d = StFinish;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = StShift;
                end
            end

            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            for (int i = 0; i < WORDS; i++) begin
                row_q[i] <= '0;
            end
`ifdef WEIGHT_LOADER_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_q      <= row_d;
`ifdef WEIGHT_LOADER_PARITY_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter WORD_W, default 10, width of one weight word.
REQ-002 Parameter WORDS, default 10, weight words per row (one neuron).
REQ-003 Parameter ROWS, default 10, rows per load (neurons per layer).
REQ-004 Parameter ADDR_W, default 5, row address width.
REQ-005 Clock  input  1  clock; all logic on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a full load.
REQ-008 in_valid  input  1  serial bit qualifier.
REQ-009 in_bit  input  1  serial weight data, MSB first, word 0 first.
REQ-010 in_ready  output  1  high while the loader accepts serial bits.
REQ-011 wr_en  output  1  single-cycle row-write strobe to the weight RAM.
REQ-012 wr_addr  output  ADDR_W  row address for wr_en.
REQ-013 wr_data  output  WORDS x WORD_W  unpacked row; word 0 is entry 0.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  single-cycle pulse after the last row is written.
REQ-016 err  output  1  sticky parity-error flag.

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT, WRITE and FINISH.
REQ-018 From IDLE, start SHALL move to SHIFT and clear the row counter, word counter, bit counter and err; start in any other state SHALL be ignored.
REQ-019 In SHIFT, in_ready SHALL be 1, and each cycle with in_valid=1 SHALL shift in_bit into the LSB of the current word and advance the bit counter.
REQ-020 A cycle with in_valid=0 in SHIFT SHALL hold all state (stall); there is no timeout.
REQ-021 When the last bit of word WORDS-1 is accepted, the FSM SHALL go to WRITE on the next edge.
REQ-022 In WRITE, wr_en SHALL be 1 for exactly one cycle, wr_addr SHALL equal the row counter and wr_data SHALL hold the assembled row; in_ready SHALL be 0.
REQ-023 After WRITE, the FSM SHALL return to SHIFT with the row counter incremented, or SHALL go to FINISH if the row counter equals ROWS-1.
REQ-024 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-025 wr_data SHALL stay stable outside WRITE until the first bit of the next row is shifted.
REQ-026 A row SHALL NOT be written while any of its words is incomplete.
REQ-027 Minimum load latency from start to done SHALL be 1 + ROWS*(WORDS*WORD_W + 1) + 1 cycles with in_valid held high.

Reset
REQ-028 Reset SHALL force the FSM to IDLE and set in_ready, wr_en, busy, done, err and all counters to 0; wr_data SHALL reset to all zeros.
REQ-029 Reset in the middle of a load SHALL abort it without issuing any further wr_en; rows already written SHALL NOT be retracted.

Configuration
REQ-030 With WEIGHT_LOADER_PARITY_EN defined, each word SHALL be followed by one even-parity bit (WORD_W+1 bits per word).
REQ-031 With WEIGHT_LOADER_PARITY_EN defined, a parity mismatch SHALL set err, suppress the write of that row and return the FSM to IDLE without done.
REQ-032 Without WEIGHT_LOADER_PARITY_EN, err SHALL be tied to 0 and no parity bit SHALL be expected.

Structure
REQ-033 The shared package nn_pkg SHALL hold the WORD_W, WORDS, ROWS and ADDR_W defaults, the row typedef and the FSM state enum.
REQ-034 A single sub-module, serial_word_shifter, SHALL assemble one word and its optional parity check; the row assembly, counters and FSM SHALL stay in weight_loader.

Verification
REQ-035 Reset, start, then 1000 bits with in_valid=1 encoding weights w[r][k]=r*10+k -> ten wr_en pulses at addr 0..9 carrying matching rows, done exactly 1012 cycles after start.
REQ-036 Same load with in_valid toggled pseudo-randomly at 50% -> identical writes and done; no wr_en while a row is partial.
REQ-037 start asserted again mid-load at row 4 -> ignored; the load completes normally with 10 writes.
REQ-038 Reset asserted after row 3 is written -> no further wr_en; busy=0, in_ready=0 on the next cycle; a new start reloads from addr 0.
REQ-039 With WEIGHT_LOADER_PARITY_EN defined and a bad parity bit injected on row 2, word 5 -> rows 0 and 1 written, no write at addr 2, err=1, no done.
REQ-040 Without the macro, a stream containing extra parity bits -> word misalignment is visible in wr_data; err stays 0.
